fdl_ctrl: RTL and testbench

- Digital controller that produces the 6-bit fine-delay code `Q[5:0]` and its complement `Qb[5:0]`, which drive the fine delay line of the FMDLL.
- Takes phase-detector early/late decisions from the DLL loop.
- Finds the code by a 6-step successive-approximation (binary) search, then tracks drift with ±1 steps through a digital loop filter.
- Asserts `locked` once the code has been stable for a programmable number of decisions.

---
 rtl/fdl_pkg.sv | 17 +
 rtl/fdl_loop_filter.sv | 61 ++++++
 rtl/fdl_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_fdl_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fdl_pkg.sv
// Shared types and default constants for the FMDLL fine-delay-line controller.
package fdl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SEARCH = 2'd1,
    TRACK  = 2'd2,
    LOCKED = 2'd3
  } fdl_state_e;

  localparam int         FDL_WIDTH      = 6;
  localparam logic [5:0] FDL_MID        = 6'b100000;
  localparam int         FDL_SETTLE     = 4;
  localparam int         FDL_FILT_DEPTH = 4;
  localparam int         FDL_LOCK_CNT   = 8;

endpackage

// File: rtl/fdl_loop_filter.sv
// Signed vote accumulator: emits a one-cycle step request when the net
// phase-detector votes reach +/-FILT_DEPTH, then restarts from zero.
module fdl_loop_filter #(
  parameter int FILT_DEPTH = 4
) (
  input  logic clk_in,
  input  logic reset,
  input  logic clear,
  input  logic vote_valid,
  input  logic vote_up,
  input  logic vote_dn,
  output logic step_up,
  output logic step_dn
);

  localparam int AW = $clog2(FILT_DEPTH + 1) + 2;
  localparam logic signed [AW-1:0] DEPTH_P = AW'(FILT_DEPTH);
  localparam logic signed [AW-1:0] DEPTH_N = -DEPTH_P;

  logic signed [AW-1:0] acc_q, acc_d;
  logic signed [AW-1:0] vote;
  logic signed [AW-1:0] sum;

  // Fold the vote into the accumulator and raise a step request at threshold
  always_comb begin
    vote    = '0;
    sum     = '0;
    acc_d   = acc_q;
    step_up = 1'b0;
    step_dn = 1'b0;
    if (vote_up && !vote_dn) begin
      vote = AW'(1);
    end else if (vote_dn && !vote_up) begin
      vote = -AW'(1);
    end
    sum = acc_q + vote;
    if (clear) begin
      acc_d = '0;
    end else if (vote_valid) begin
      if (sum >= DEPTH_P) begin
        step_up = 1'b1;
        acc_d   = '0;
      end else if (sum <= DEPTH_N) begin
        step_dn = 1'b1;
        acc_d   = '0;
      end else begin
        acc_d = sum;
      end
    end
  end

  // Accumulator register
  always_ff @(posedge clk_in) begin
    if (reset) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/fdl_ctrl.sv
// Fine-delay-line controller: successive-approximation search for the delay
// code, followed by filtered +/-1 tracking and lock detection.
module fdl_ctrl
  import fdl_pkg::*;
#(
  parameter int WIDTH      = FDL_WIDTH,
  parameter int SETTLE     = FDL_SETTLE,
  parameter int FILT_DEPTH = FDL_FILT_DEPTH,
  parameter int LOCK_CNT   = FDL_LOCK_CNT
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             enable,
  input  logic             pd_valid,
  input  logic             pd_up,
  input  logic             pd_dn,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] Qb,
  output logic             locked,
  output logic             at_max,
  output logic             at_min,
  output logic             sat_err
);

  localparam int BW = $clog2(WIDTH);
  localparam int SW = $clog2(SETTLE + 1);
  localparam int LW = $clog2(LOCK_CNT + 1);

  localparam logic [WIDTH-1:0] MID      = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [WIDTH-1:0] Q_MAX    = '1;
  localparam logic [BW-1:0]    TOP_BIT  = BW'(WIDTH - 1);
  localparam logic [SW-1:0]    SETTLE_V = SW'(SETTLE);
  localparam logic [LW-1:0]    LOCK_V   = LW'(LOCK_CNT);

  fdl_state_e       state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [SW-1:0]    settle_q, settle_d;
  logic [LW-1:0]    lock_q, lock_d;
  logic             locked_q, locked_d;
  logic             at_max_q, at_max_d;
  logic             at_min_q, at_min_d;
  logic             sat_err_q, sat_err_d;

  logic sample;
  logic filt_clear;
  logic filt_valid;
  logic step_up;
  logic step_dn;

  fdl_loop_filter #(
    .FILT_DEPTH(FILT_DEPTH)
  ) u_filter (
    .clk_in    (clk_in),
    .reset     (reset),
    .clear     (filt_clear),
    .vote_valid(filt_valid),
    .vote_up   (pd_up),
    .vote_dn   (pd_dn),
    .step_up   (step_up),
    .step_dn   (step_dn)
  );

  // Next-state, SAR bit decisions, tracking steps, settle blanking and lock counting
  always_comb begin
    state_d    = state_q;
    q_d        = q_q;
    bit_d      = bit_q;
    settle_d   = settle_q;
    lock_d     = lock_q;
    sat_err_d  = sat_err_q;
    filt_clear = 1'b0;
    filt_valid = 1'b0;
    sample     = pd_valid && (settle_q == '0);

    if (settle_q != '0) begin
      settle_d = settle_q - 1'b1;
    end

    if (!enable) begin
      state_d    = IDLE;
      q_d        = MID;
      bit_d      = TOP_BIT;
      settle_d   = '0;
      lock_d     = '0;
      sat_err_d  = 1'b0;
      filt_clear = 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          state_d    = SEARCH;
          q_d        = MID;
          bit_d      = TOP_BIT;
          settle_d   = SETTLE_V;
          filt_clear = 1'b1;
        end
        SEARCH: begin
          if (sample) begin
            if (!pd_up) begin
              q_d[bit_q] = 1'b0;
            end
            if (bit_q != '0) begin
              q_d[bit_q - 1'b1] = 1'b1;
              bit_d             = bit_q - 1'b1;
            end else begin
              state_d    = TRACK;
              lock_d     = '0;
              filt_clear = 1'b1;
            end
          end
        end
        TRACK, LOCKED: begin
          if (sample) begin
            filt_valid = 1'b1;
            if (step_up || step_dn) begin
              lock_d = '0;
              if (step_up && (q_q != Q_MAX)) begin
                q_d = q_q + 1'b1;
              end else if (step_dn && (q_q != '0)) begin
                q_d = q_q - 1'b1;
              end else begin
                sat_err_d = 1'b1;
                state_d   = TRACK;
              end
            end else begin
              if (lock_q != LOCK_V) begin
                lock_d = lock_q + 1'b1;
              end
              if ((state_q == TRACK) && (lock_d == LOCK_V)) begin
                state_d = LOCKED;
              end
            end
          end
        end
        default: begin
          state_d = IDLE;
          q_d     = MID;
        end
      endcase

      if ((state_q != IDLE) && (q_d != q_q)) begin
        settle_d = SETTLE_V;
      end
    end

    locked_d = (state_d == LOCKED);
    at_max_d = (q_d == Q_MAX);
    at_min_d = (q_d == '0);
  end

  // State and output registers with synchronous reset
  always_ff @(posedge clk_in) begin
    if (reset) begin
      state_q   <= IDLE;
      q_q       <= MID;
      bit_q     <= TOP_BIT;
      settle_q  <= '0;
      lock_q    <= '0;
      locked_q  <= 1'b0;
      at_max_q  <= 1'b0;
      at_min_q  <= 1'b0;
      sat_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      q_q       <= q_d;
      bit_q     <= bit_d;
      settle_q  <= settle_d;
      lock_q    <= lock_d;
      locked_q  <= locked_d;
      at_max_q  <= at_max_d;
      at_min_q  <= at_min_d;
      sat_err_q <= sat_err_d;
    end
  end

  assign Q       = q_q;
  assign Qb      = ~q_q;
  assign locked  = locked_q;
  assign at_max  = at_max_q;
  assign at_min  = at_min_q;
  assign sat_err = sat_err_q;

endmodule

// File: tb/tb_fdl_ctrl.sv
// Self-checking bench for fdl_ctrl: closed-loop phase-detector model with
// randomized valid pulses, checked against an integer reference model.
module tb_fdl_ctrl;

  localparam int SETTLE = 4;
  localparam int DEPTH  = 4;
  localparam int LOCKN  = 8;

  localparam int M_IDLE   = 0;
  localparam int M_SEARCH = 1;
  localparam int M_TRACK  = 2;
  localparam int M_LOCKED = 3;

  logic       clk_in = 1'b0;
  logic       reset;
  logic       enable;
  logic       pd_valid;
  logic       pd_up;
  logic       pd_dn;
  logic [5:0] Q;
  logic [5:0] Qb;
  logic       locked;
  logic       at_max;
  logic       at_min;
  logic       sat_err;

  fdl_ctrl dut (
    .clk_in  (clk_in),
    .reset   (reset),
    .enable  (enable),
    .pd_valid(pd_valid),
    .pd_up   (pd_up),
    .pd_dn   (pd_dn),
    .Q       (Q),
    .Qb      (Qb),
    .locked  (locked),
    .at_max  (at_max),
    .at_min  (at_min),
    .sat_err (sat_err)
  );

  // Free-running reference clock
  always #5 clk_in = ~clk_in;

  int errors = 0;
  int checks = 0;

  // Reference model state: code as an integer, SAR trial weight, net votes
  int m_mode   = M_IDLE;
  int m_code   = 32;
  int m_weight = 32;
  int m_blank  = 0;
  int m_net    = 0;
  int m_lock   = 0;
  int m_sat    = 0;
  bit m_live   = 1'b0;

  // Stimulus knobs
  int tgt       = 45;
  int valid_pct = 100;
  bit both_mode = 1'b0;
  bit rand_pd   = 1'b0;
  bit dither    = 1'b0;

  task automatic checkOutput(input string tag, input int observed, input int expected);
    checks++;
    if (observed != expected) begin
      errors++;
      $display("[TB] FAIL %s: observed=%0d expected=%0d at %0t", tag, observed, expected, $time);
    end
  endtask

  // Drive the PD inputs for the coming edge from the model's view of the code
  task automatic applyStimulus();
    pd_valid = ($urandom_range(0, 99) < valid_pct);
    if (rand_pd) begin
      pd_up = 1'($urandom_range(0, 1));
      pd_dn = 1'($urandom_range(0, 1));
    end else if (both_mode) begin
      pd_up = 1'b1;
      pd_dn = 1'b1;
    end else if ((m_mode == M_SEARCH) || (m_code != tgt)) begin
      pd_up = (m_code <= tgt);
      pd_dn = !pd_up;
    end else begin
      if (pd_valid) dither = !dither;
      pd_up = dither;
      pd_dn = !dither;
    end
  endtask

  // Advance the reference model by one clock using the inputs just applied
  task automatic modelStep();
    int old_code;
    int v;
    int dir;
    int nc;
    bit sampled;
    if (reset) begin
      m_mode = M_IDLE; m_code = 32; m_weight = 32; m_blank = 0;
      m_net = 0; m_lock = 0; m_sat = 0; m_live = 1'b1;
    end else if (!enable) begin
      m_mode = M_IDLE; m_code = 32; m_weight = 32; m_blank = 0;
      m_net = 0; m_lock = 0; m_sat = 0;
    end else if (m_mode == M_IDLE) begin
      m_mode = M_SEARCH; m_code = 32; m_weight = 32; m_blank = SETTLE; m_net = 0;
    end else begin
      sampled  = pd_valid && (m_blank == 0);
      old_code = m_code;
      if (m_blank > 0) m_blank--;
      if (sampled) begin
        if (m_mode == M_SEARCH) begin
          if (!pd_up) m_code -= m_weight;
          m_weight /= 2;
          if (m_weight > 0) begin
            m_code += m_weight;
          end else begin
            m_mode = M_TRACK; m_net = 0; m_lock = 0;
          end
        end else begin
          v = (pd_up && !pd_dn) ? 1 : ((pd_dn && !pd_up) ? -1 : 0);
          m_net += v;
          if ((m_net >= DEPTH) || (m_net <= -DEPTH)) begin
            dir = (m_net > 0) ? 1 : -1;
            nc = m_code + dir;
            m_net = 0; m_lock = 0;
            if ((nc >= 0) && (nc <= 63)) begin
              m_code = nc;
            end else begin
              m_sat = 1; m_mode = M_TRACK;
            end
          end else begin
            if (m_lock < LOCKN) m_lock++;
            if ((m_mode == M_TRACK) && (m_lock == LOCKN)) m_mode = M_LOCKED;
          end
        end
      end
      if (m_code != old_code) m_blank = SETTLE;
    end
  endtask

  // One clock: drive, update model at the edge, compare at the falling edge
  task automatic tick();
    logic [5:0] q_inv;
    applyStimulus();
    @(posedge clk_in);
    modelStep();
    @(negedge clk_in);
    q_inv = ~Q;
    checkOutput("qb_is_not_q", int'(Qb), int'(q_inv));
    if (m_live) begin
      checkOutput("q_model", int'(Q), m_code);
      checkOutput("locked_model", int'(locked), (m_mode == M_LOCKED) ? 1 : 0);
      checkOutput("sat_err_model", int'(sat_err), m_sat);
      checkOutput("at_max_model", int'(at_max), (m_code == 63) ? 1 : 0);
      checkOutput("at_min_model", int'(at_min), (m_code == 0) ? 1 : 0);
    end
  endtask

  task automatic waitMode(input int mode, input int budget, input string tag);
    int n;
    n = 0;
    while ((m_mode != mode) && (n < budget)) begin
      tick();
      n++;
    end
    checkOutput(tag, (m_mode == mode) ? 1 : 0, 1);
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    reset = 1'b1; enable = 1'b1;
    pd_valid = 1'b0; pd_up = 1'b0; pd_dn = 1'b0;

    // Reset held three cycles with enable high
    repeat (3) tick();
    checkOutput("rst_q", int'(Q), 32);
    checkOutput("rst_qb", int'(Qb), 31);
    checkOutput("rst_locked", int'(locked), 0);
    checkOutput("rst_at_min", int'(at_min), 0);
    checkOutput("rst_at_max", int'(at_max), 0);
    checkOutput("rst_sat_err", int'(sat_err), 0);
    reset = 1'b0;

    // Binary search toward 45
    tgt = 45; valid_pct = 100;
    waitMode(M_TRACK, 300, "search45_done");
    checkOutput("search45_q", int'(Q), 45);

    // Hold votes in TRACK: no step, lock counter still advances
    both_mode = 1'b1; valid_pct = 70;
    repeat (20) tick();
    checkOutput("hold_q", int'(Q), 45);
    checkOutput("hold_locked", int'(locked), 1);
    both_mode = 1'b0;

    // Dither around 45 keeps the lock
    valid_pct = 100;
    repeat (30) tick();
    checkOutput("dither_q", int'(Q), 45);
    checkOutput("dither_locked", int'(locked), 1);

    // Target moves to 47: two tracking steps, lock retained
    tgt = 47;
    repeat (80) tick();
    checkOutput("track47_q", int'(Q), 47);
    checkOutput("track47_locked", int'(locked), 1);
    checkOutput("track47_sat", int'(sat_err), 0);

    // Drop enable from LOCKED
    enable = 1'b0;
    tick();
    checkOutput("dis_q", int'(Q), 32);
    checkOutput("dis_locked", int'(locked), 0);

    // Re-enable, then drop enable at bit index 3 of the search
    enable = 1'b1; tgt = 45; valid_pct = 60;
    n = 0;
    while (!((m_mode == M_SEARCH) && (m_weight == 8)) && (n < 300)) begin
      tick();
      n++;
    end
    checkOutput("bit3_reached", ((m_mode == M_SEARCH) && (m_weight == 8)) ? 1 : 0, 1);
    enable = 1'b0;
    tick();
    checkOutput("abort_q", int'(Q), 32);
    checkOutput("abort_locked", int'(locked), 0);

    // Restart toward an unreachable target: search pins at 63 then saturates
    enable = 1'b1; tgt = 70; valid_pct = 100;
    waitMode(M_TRACK, 300, "search70_done");
    checkOutput("search70_q", int'(Q), 63);
    checkOutput("search70_at_max", int'(at_max), 1);
    repeat (40) tick();
    checkOutput("sat_q", int'(Q), 63);
    checkOutput("sat_flag", int'(sat_err), 1);

    // Reset in the middle of tracking
    reset = 1'b1;
    tick();
    checkOutput("midrst_q", int'(Q), 32);
    checkOutput("midrst_sat", int'(sat_err), 0);
    reset = 1'b0;

    // Randomized phase: random targets, valid rates, occasional enable drops
    for (int i = 0; i < 700; i++) begin
      if ((i % 140) == 0) tgt = (i == 0) ? 0 : $urandom_range(0, 63);
      rand_pd   = (i >= 560);
      valid_pct = $urandom_range(50, 100);
      enable    = ($urandom_range(0, 149) != 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
